axis_pkt_bram_writer: RTL

Parametrised AXI-Stream slave that writes packets into a circular BRAM region using per-byte write enables taken from t_keep.
Each completed packet (t_last) produces one descriptor: start address, length in beats, last-beat keep.
A downstream consumer returns space via a release port.
Sits between a stream source and the packet BRAM.

---
 rtl/axis_wr_pkg.sv | 28 ++
 rtl/axis_keep_popcount.sv | 17 +
 rtl/axis_pkt_bram_writer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/axis_wr_pkg.sv
// Shared types and constant helpers for the AXI-Stream packet BRAM writer.
// AXIS_WR_BYTECNT_EN adds a byte-count field to the descriptor view.
package axis_wr_pkg;

    typedef enum logic {RX = 1'b0, DESC = 1'b1} wr_state_t;

    localparam int DEF_COUNTER_W = 10;
    localparam int DEF_KEEP_W    = 64;

    // Descriptor view at the default configuration (counter_width=10, 64 lanes)
    typedef struct packed {
        logic [DEF_COUNTER_W-1:0] addr;
        logic [DEF_COUNTER_W:0]   len;
        logic [DEF_KEEP_W-1:0]    keep;
`ifdef AXIS_WR_BYTECNT_EN
        logic [DEF_COUNTER_W+7:0] bytes;
`endif
    } desc_t;

    function automatic int len_width(input int counter_w);
        return counter_w + 1;
    endfunction

    function automatic int ptr_wrap(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational population count of a byte-qualifier vector.
module axis_keep_popcount #(
    parameter int keep_width  = 64,
    parameter int count_width = $clog2(keep_width + 1)
) (
    input  logic [keep_width-1:0]  keep,
    output logic [count_width-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < keep_width; i++) begin
            count = count + count_width'(keep[i]);
        end
    end

endmodule

// File: rtl/axis_pkt_bram_writer.sv
// AXI-Stream slave writing packets into a circular BRAM region, one descriptor per packet.
// Optional AXIS_WR_BYTECNT_EN adds desc_bytes (set t_keep bits across the packet).
module axis_pkt_bram_writer
    import axis_wr_pkg::*;
#(
    parameter int data_width     = 512,
    parameter int keep_width     = data_width / 8,
    parameter int counter_width  = 10,
    parameter int mem_size_depth = 1024
) (
    input  logic                     axis_clk,
    input  logic                     reset,
    input  logic                     t_valid,
    input  logic [data_width-1:0]    t_data,
    input  logic [keep_width-1:0]    t_keep,
    input  logic                     t_last,
    output logic                     t_ready,
    output logic                     bram_ena,
    output logic [keep_width-1:0]    bram_wena,
    output logic [counter_width-1:0] bram_address,
    output logic [data_width-1:0]    bram_data,
    output logic                     desc_valid,
    input  logic                     desc_ready,
    output logic [counter_width-1:0] desc_addr,
    output logic [counter_width:0]   desc_len,
    output logic [keep_width-1:0]    desc_keep,
`ifdef AXIS_WR_BYTECNT_EN
    output logic [counter_width+7:0] desc_bytes,
`endif
    input  logic                     rel_valid,
    input  logic [counter_width:0]   rel_beats,
    output logic [counter_width:0]   free_count,
    output logic                     rel_err
);

    localparam int LEN_W  = len_width(counter_width);
    localparam int FREE_W = counter_width + 2;
    localparam logic [FREE_W-1:0] DEPTH_WIDE = FREE_W'(mem_size_depth);
    localparam logic [LEN_W-1:0]  DEPTH_LEN  = LEN_W'(mem_size_depth);

    wr_state_t                state, state_nxt;
    logic [counter_width-1:0] wr_ptr, wr_ptr_nxt, pkt_start;
    logic [LEN_W-1:0]         beat_cnt, beat_now;
    logic [keep_width-1:0]    last_keep, keep_now;
    logic [FREE_W-1:0]        free_sum;
    logic [LEN_W-1:0]         free_nxt;
    logic                     accept, wr_beat, eop, over;

`ifdef AXIS_WR_BYTECNT_EN
    localparam int POP_W   = $clog2(keep_width + 1);
    localparam int BYTES_W = counter_width + 8;
    logic [POP_W-1:0]   keep_pop;
    logic [BYTES_W-1:0] bytes_acc, bytes_now;

    axis_keep_popcount #(
        .keep_width (keep_width),
        .count_width(POP_W)
    ) u_keep_popcount (
        .keep (t_keep),
        .count(keep_pop)
    );

    assign bytes_now = accept ? bytes_acc + BYTES_W'(keep_pop) : bytes_acc;
`endif

    always_comb begin
        accept     = t_valid && t_ready;
        wr_beat    = accept && (t_keep != '0);
        eop        = accept && t_last;
        beat_now   = beat_cnt + LEN_W'(wr_beat);
        keep_now   = wr_beat ? t_keep : last_keep;
        wr_ptr_nxt = wr_beat ? counter_width'(ptr_wrap(32'(wr_ptr), mem_size_depth)) : wr_ptr;
        // Release and write may land on the same edge; saturate on over-release
        free_sum   = {1'b0, free_count} + (rel_valid ? {1'b0, rel_beats} : '0) - FREE_W'(wr_beat);
        over       = free_sum > DEPTH_WIDE;
        free_nxt   = over ? DEPTH_LEN : free_sum[LEN_W-1:0];
        state_nxt  = state;
        case (state)
            RX:      if (eop && beat_now != '0) state_nxt = DESC;
            DESC:    if (desc_ready) state_nxt = RX;
            default: state_nxt = RX;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!reset) begin
            state        <= RX;
            t_ready      <= 1'b0;
            bram_ena     <= 1'b0;
            bram_wena    <= '0;
            bram_address <= '0;
            bram_data    <= '0;
            desc_valid   <= 1'b0;
            desc_addr    <= '0;
            desc_len     <= '0;
            desc_keep    <= '0;
            free_count   <= DEPTH_LEN;
            rel_err      <= 1'b0;
            wr_ptr       <= '0;
            pkt_start    <= '0;
            beat_cnt     <= '0;
            last_keep    <= '0;
`ifdef AXIS_WR_BYTECNT_EN
            bytes_acc    <= '0;
            desc_bytes   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            t_ready    <= (state_nxt == RX) && (free_nxt != '0);
            free_count <= free_nxt;
            if (over) rel_err <= 1'b1;

            bram_ena  <= wr_beat;
            bram_wena <= wr_beat ? t_keep : '0;
            if (wr_beat) begin
                bram_address <= wr_ptr;
                bram_data    <= t_data;
                last_keep    <= t_keep;
            end
            wr_ptr <= wr_ptr_nxt;

            if (eop) begin
                pkt_start <= wr_ptr_nxt;
                beat_cnt  <= '0;
`ifdef AXIS_WR_BYTECNT_EN
                bytes_acc <= '0;
`endif
                if (beat_now != '0) begin
                    desc_valid <= 1'b1;
                    desc_addr  <= pkt_start;
                    desc_len   <= beat_now;
                    desc_keep  <= keep_now;
`ifdef AXIS_WR_BYTECNT_EN
                    desc_bytes <= bytes_now;
`endif
                end
            end else begin
                beat_cnt <= beat_now;
`ifdef AXIS_WR_BYTECNT_EN
                bytes_acc <= bytes_now;
`endif
                if (state == DESC && desc_ready) desc_valid <= 1'b0;
            end
        end
    end

endmodule
